// File: rtl/block_redraw_scheduler.sv
// block_redraw_scheduler: sequences every framebuffer write for the moving block.
// On each accepted sync tick it erases the previously drawn rectangle when the
// block has moved, draws the block at its latched position, and, with the macro
// BLOCK_REDRAW_HUD_EN defined, repaints the chances bar. It emits one pixel per
// clock. Pixels that fall off the 160x120 screen are clipped (plot low) but still
// take their cycle.
module block_redraw_scheduler #(
   parameter int unsigned BLOCK_W   = 20,
   parameter int unsigned BLOCK_H   = 4,
   parameter logic [2:0]  BG_COLOUR = 3'b000,
   parameter logic [2:0]  FG_COLOUR = 3'b111
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       sync,
   input  logic [7:0] blk_x,
   input  logic [6:0] blk_y,
   input  logic [3:0] chance,
   input  logic [1:0] game_status,
   output logic       plot,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] colour,
   output logic       busy,
   output logic       done
);

   localparam logic [5:0] LAST_COL = 6'(BLOCK_W - 1);
   localparam logic [3:0] LAST_ROW = 4'(BLOCK_H - 1);
`ifdef BLOCK_REDRAW_HUD_EN
   // Chances bar: 15 slots of 4 px across x=0..59, two rows tall.
   localparam logic [5:0] HUD_LAST_COL = 6'd59;
   localparam logic [3:0] HUD_LAST_ROW = 4'd1;
   localparam logic [2:0] HUD_COLOUR   = 3'b010;
`endif

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_ERASE,
      ST_DRAW,
`ifdef BLOCK_REDRAW_HUD_EN
      ST_HUD,
`endif
      ST_DONE
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] col_q, col_d;
   logic [3:0] row_q, row_d;
   logic [7:0] wx_q, wx_d;
   logic [6:0] wy_q, wy_d;
   logic [3:0] wc_q, wc_d;
   logic [7:0] prev_x_q, prev_x_d;
   logic [6:0] prev_y_q, prev_y_d;
   logic       prev_valid_q, prev_valid_d;
   logic       pending_q, pending_d;

   logic       plot_q;
   logic [7:0] vga_x_q;
   logic [6:0] vga_y_q;
   logic [2:0] colour_q;
   logic       busy_q, done_q;

   // Scan bookkeeping and the pixel to present in the next cycle.
   logic [5:0] last_col;
   logic [3:0] last_row;
   logic       scanning, scan_end;
   logic       scan_d;
   logic [8:0] px_d;
   logic [7:0] py_d;
   logic [2:0] colour_d;
   logic       plot_d;

`ifndef BLOCK_REDRAW_HUD_EN
   // The latched chance count only feeds the chances bar.
   logic unused_chance;
   assign unused_chance = ^wc_q;
`endif

   // Next-state, scan counter and next-pixel computation.
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      wx_d         = wx_q;
      wy_d         = wy_q;
      wc_d         = wc_q;
      prev_x_d     = prev_x_q;
      prev_y_d     = prev_y_q;
      prev_valid_d = prev_valid_q;
      // A sync that arrives while a redraw is in flight is remembered once.
      pending_d    = pending_q | (sync & (state_q != ST_IDLE));

      last_col = LAST_COL;
      last_row = LAST_ROW;
`ifdef BLOCK_REDRAW_HUD_EN
      if (state_q == ST_HUD) begin
         last_col = HUD_LAST_COL;
         last_row = HUD_LAST_ROW;
      end
      scanning = (state_q == ST_ERASE) || (state_q == ST_DRAW) || (state_q == ST_HUD);
`else
      scanning = (state_q == ST_ERASE) || (state_q == ST_DRAW);
`endif
      scan_end = (col_q == last_col) && (row_q == last_row);

      // Column is the inner loop; both counters return to zero at scan end.
      if (scanning) begin
         if (col_q == last_col) begin
            col_d = '0;
            row_d = scan_end ? 4'd0 : row_q + 4'd1;
         end else begin
            col_d = col_q + 6'd1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (sync || pending_q) begin
               pending_d = 1'b0;
               // Ticks during game over are dropped.
               if (game_status != 2'b11) state_d = ST_LATCH;
            end
         end
         ST_LATCH: begin
            wx_d = blk_x;
            wy_d = blk_y;
            wc_d = chance;
            if (prev_valid_q && ({prev_x_q, prev_y_q} != {blk_x, blk_y}))
               state_d = ST_ERASE;
            else
               state_d = ST_DRAW;
         end
         ST_ERASE: begin
            if (scan_end) state_d = ST_DRAW;
         end
         ST_DRAW: begin
            if (scan_end) begin
               prev_x_d     = wx_q;
               prev_y_d     = wy_q;
               prev_valid_d = 1'b1;
`ifdef BLOCK_REDRAW_HUD_EN
               state_d = ST_HUD;
`else
               state_d = ST_DONE;
`endif
            end
         end
`ifdef BLOCK_REDRAW_HUD_EN
         ST_HUD: begin
            if (scan_end) state_d = ST_DONE;
         end
`endif
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Pixel for the state being entered, so outputs line up with that state.
      px_d     = '0;
      py_d     = '0;
      colour_d = '0;
      scan_d   = 1'b0;
      case (state_d)
         ST_ERASE: begin
            px_d     = {1'b0, prev_x_q} + {3'b000, col_d};
            py_d     = {1'b0, prev_y_q} + {4'b0000, row_d};
            colour_d = BG_COLOUR;
            scan_d   = 1'b1;
         end
         ST_DRAW: begin
            px_d     = {1'b0, wx_d} + {3'b000, col_d};
            py_d     = {1'b0, wy_d} + {4'b0000, row_d};
            colour_d = FG_COLOUR;
            scan_d   = 1'b1;
         end
`ifdef BLOCK_REDRAW_HUD_EN
         ST_HUD: begin
            px_d     = {3'b000, col_d};
            py_d     = {4'b0000, row_d};
            colour_d = (col_d[5:2] < wc_d) ? HUD_COLOUR : BG_COLOUR;
            scan_d   = 1'b1;
         end
`endif
         default: ;
      endcase
      plot_d = scan_d && (px_d < 9'd160) && (py_d < 8'd120);
   end

   // FSM state, working registers and registered pixel outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         col_q        <= '0;
         row_q        <= '0;
         wx_q         <= '0;
         wy_q         <= '0;
         wc_q         <= '0;
         prev_x_q     <= '0;
         prev_y_q     <= '0;
         prev_valid_q <= 1'b0;
         pending_q    <= 1'b0;
         plot_q       <= 1'b0;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         colour_q     <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         wx_q         <= wx_d;
         wy_q         <= wy_d;
         wc_q         <= wc_d;
         prev_x_q     <= prev_x_d;
         prev_y_q     <= prev_y_d;
         prev_valid_q <= prev_valid_d;
         pending_q    <= pending_d;
         plot_q       <= plot_d;
         vga_x_q      <= px_d[7:0];
         vga_y_q      <= py_d[6:0];
         colour_q     <= colour_d;
         busy_q       <= (state_d != ST_IDLE);
         done_q       <= (state_d == ST_DONE);
      end
   end

   assign plot   = plot_q;
   assign vga_x  = vga_x_q;
   assign vga_y  = vga_y_q;
   assign colour = colour_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_block_redraw_scheduler.sv
// tb_block_redraw_scheduler: randomized redraw requests checked cycle by cycle
// against a pixel-list reference model of the redraw rules.
module tb_block_redraw_scheduler;

   localparam int W = 20;
   localparam int H = 4;

   logic       clk = 1'b0;
   logic       resetn;
   logic       sync;
   logic [7:0] blk_x;
   logic [6:0] blk_y;
   logic [3:0] chance;
   logic [1:0] game_status;
   logic       plot;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] colour;
   logic       busy;
   logic       done;

   always #5 clk = ~clk;

   block_redraw_scheduler dut (
      .clk         (clk),
      .resetn      (resetn),
      .sync        (sync),
      .blk_x       (blk_x),
      .blk_y       (blk_y),
      .chance      (chance),
      .game_status (game_status),
      .plot        (plot),
      .vga_x       (vga_x),
      .vga_y       (vga_y),
      .colour      (colour),
      .busy        (busy),
      .done        (done)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: remembered rectangle plus the expected per-cycle pixel list.
   typedef struct {
      bit p;
      int x;
      int y;
      int c;
   } pix_t;

   bit   m_prev_valid = 1'b0;
   int   m_prev_x = 0;
   int   m_prev_y = 0;
   pix_t exp_q[$];

   task automatic add_rect(input int bx, input int by, input int c);
      pix_t e;
      for (int r = 0; r < H; r++)
         for (int k = 0; k < W; k++) begin
            e.x = bx + k;
            e.y = by + r;
            e.p = (e.x < 160) && (e.y < 120);
            e.c = c;
            exp_q.push_back(e);
         end
   endtask

   // One redraw from the IDLE negedge to the IDLE negedge after DONE.
   task automatic run_redraw(input int x, input int y, input int ch,
                             input bit from_pending, input int n_extra, input bit sync_at_done);
      pix_t e;
      int   extra;
      extra = n_extra;
      exp_q.delete();
      if (m_prev_valid && (m_prev_x != x || m_prev_y != y)) add_rect(m_prev_x, m_prev_y, 0);
      add_rect(x, y, 7);
`ifdef BLOCK_REDRAW_HUD_EN
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < 60; k++) begin
            e.x = k;
            e.y = r;
            e.p = 1'b1;
            e.c = ((k / 4) < ch) ? 2 : 0;
            exp_q.push_back(e);
         end
`endif
      blk_x  = 8'(x);
      blk_y  = 7'(y);
      chance = 4'(ch);
      sync   = !from_pending;
      @(negedge clk);
      sync = 1'b0;
      check_eq("latch_busy", busy, 1);
      check_eq("latch_plot", plot, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         sync = 1'b0;
         if (i == 0) begin
            // Inputs are latched already; changing them must not matter.
            blk_x  = 8'($urandom);
            blk_y  = 7'($urandom);
            chance = 4'($urandom);
         end
         if (extra > 0 && (i % 7) == 3) begin
            sync = 1'b1;
            extra--;
         end
         e = exp_q[i];
         check_eq("scan_plot", plot, e.p);
         check_eq("scan_busy", busy, 1);
         check_eq("scan_done", done, 0);
         if (e.p) begin
            check_eq("scan_x", vga_x, e.x);
            check_eq("scan_y", vga_y, e.y);
            check_eq("scan_colour", colour, e.c);
         end
      end
      @(negedge clk);
      sync = sync_at_done;
      check_eq("done_pulse", done, 1);
      check_eq("done_plot", plot, 0);
      check_eq("done_busy", busy, 1);
      @(negedge clk);
      sync = 1'b0;
      check_eq("idle_done", done, 0);
      check_eq("idle_busy", busy, 0);
      m_prev_valid = 1'b1;
      m_prev_x = x;
      m_prev_y = y;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  x, y, ch, ne;
      bit  sad, pend;
      resetn = 1'b0;
      sync = 1'b0;
      blk_x = '0;
      blk_y = '0;
      chance = '0;
      game_status = 2'b00;
      repeat (2) @(negedge clk);
      check_eq("rst_plot", plot, 0);
      check_eq("rst_vga_x", vga_x, 0);
      check_eq("rst_vga_y", vga_y, 0);
      check_eq("rst_colour", colour, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      resetn = 1'b1;
      @(negedge clk);

      // First draw without erase, then a move that erases, then a clipped draw.
      run_redraw(10, 50, 5, 0, 0, 0);
      run_redraw(12, 50, 5, 0, 0, 0);
      run_redraw(150, 118, 3, 0, 0, 0);

      // Three syncs during a redraw coalesce into exactly one extra redraw.
      run_redraw(30, 20, 3, 0, 3, 0);
      run_redraw(31, 20, 3, 1, 0, 0);
      repeat (3) begin
         @(negedge clk);
         check_eq("no_extra_busy", busy, 0);
      end

      // Sync coinciding with done is serviced after one IDLE cycle; same spot, no erase.
      run_redraw(40, 20, 1, 0, 0, 1);
      run_redraw(40, 20, 1, 1, 0, 0);

      // Game over drops the tick.
      game_status = 2'b11;
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
      repeat (3) begin
         check_eq("gameover_busy", busy, 0);
         check_eq("gameover_plot", plot, 0);
         @(negedge clk);
      end
      game_status = 2'b00;

      // Reset in the middle of an erase: plot drops at once, nothing is remembered.
      blk_x = 8'd44;
      blk_y = 7'd20;
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
      repeat (5) @(negedge clk);
      check_eq("erase_plot", plot, 1);
      check_eq("erase_colour", colour, 0);
      resetn = 1'b0;
      #1;
      check_eq("async_rst_plot", plot, 0);
      check_eq("async_rst_busy", busy, 0);
      @(negedge clk);
      resetn = 1'b1;
      m_prev_valid = 1'b0;
      m_prev_x = 0;
      m_prev_y = 0;
      run_redraw(60, 30, 7, 0, 0, 0);

      // Randomized redraws, including same-position, off-screen and pending cases.
      pend = 1'b0;
      for (int n = 0; n < 12; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            x = m_prev_x;
            y = m_prev_y;
         end else begin
            x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(140, 255)) : int'($urandom_range(0, 159));
            y = int'($urandom_range(0, 127));
         end
         ch  = int'($urandom_range(0, 15));
         ne  = int'($urandom_range(0, 2));
         sad = ($urandom_range(0, 3) == 0);
         run_redraw(x, y, ch, pend, ne, sad);
         pend = (ne > 0) || sad;
      end
      if (pend) run_redraw(5, 5, 2, 1, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
